mem_block_ctrl: RTL and testbench

- Backing-memory controller directly downstream of the set-associative cache.
- Consumes the cache's block-fill (read) and dirty-eviction (writeback) requests.
- Returns whole blocks after a fixed, parameterised latency.
- Serialises writeback-then-fill when both are requested in the same cycle, so a fill always observes the completed writeback.

---
 rtl/mem_block_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_block_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_ctrl.sv
// Block-oriented backing-memory controller behind the set-associative cache.
// Optional MEM_CTRL_STATS_EN adds saturating rd_count / wr_count outputs.
module mem_block_ctrl #(
  parameter int unsigned RAM_ADDRESS_BITS = 10,
  parameter int unsigned DATA_BITS        = 32,
  parameter int unsigned BLOCK_BITS       = 2,
  parameter int unsigned LATENCY          = 3,
  parameter string       MEM_INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_en,
  input  logic [RAM_ADDRESS_BITS-1:0] rd_address,
  input  logic                        wr_en,
  input  logic [RAM_ADDRESS_BITS-1:0] wr_address,
  input  logic [DATA_BITS-1:0]        wr_data [2**BLOCK_BITS],
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [2**BLOCK_BITS],
  output logic                        wr_done,
`ifdef MEM_CTRL_STATS_EN
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count,
`endif
  output logic                        busy
);

  localparam int unsigned BLOCK_SIZE = 2**BLOCK_BITS;
  localparam int unsigned RAM_WORDS  = 2**RAM_ADDRESS_BITS;
  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [RAM_ADDRESS_BITS-1:0] OFS_MASK = RAM_ADDRESS_BITS'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pending_q, pending_d;
  logic [RAM_ADDRESS_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [RAM_ADDRESS_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]        wr_data_q [BLOCK_SIZE];
  logic [DATA_BITS-1:0]        wr_data_d [BLOCK_SIZE];
  logic                        mem_we;
  logic                        rd_fire;

  logic [DATA_BITS-1:0]        mem [RAM_WORDS];

  // Time-zero contents; reset never touches the array.
  initial begin
    for (int unsigned i = 0; i < RAM_WORDS; i++) begin
      mem[i] = DATA_BITS'(i);
    end
  end

  // Next-state: writeback always runs before a same-cycle fill.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    rd_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          wr_addr_d = wr_address & ~OFS_MASK;
          wr_data_d = wr_data;
          cnt_d     = CNT_LOAD;
          state_d   = WR_BUSY;
          if (rd_en) begin
            rd_addr_d = rd_address & ~OFS_MASK;
            pending_d = 1'b1;
          end
        end else if (rd_en) begin
          rd_addr_d = rd_address & ~OFS_MASK;
          cnt_d     = CNT_LOAD;
          state_d   = RD_BUSY;
        end
      end
      WR_BUSY: begin
        if (cnt_q == '0) begin
          mem_we = 1'b1;
          if (pending_q) begin
            cnt_d     = CNT_LOAD;
            pending_d = 1'b0;
            state_d   = RD_BUSY;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_BUSY: begin
        if (cnt_q == '0) begin
          rd_fire = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      ram_valid <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
        wr_data_q[k] <= '0;
        ram_data[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ram_valid <= rd_fire;
      wr_done   <= mem_we;
      busy      <= (state_d != IDLE);
      if (rd_fire) begin
        for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
          ram_data[k] <= mem[rd_addr_q | RAM_ADDRESS_BITS'(k)];
        end
      end
    end
  end

  // Array write port: whole block commits on one edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
        mem[wr_addr_q | RAM_ADDRESS_BITS'(k)] <= wr_data_q[k];
      end
    end
  end

`ifdef MEM_CTRL_STATS_EN
  // Saturating completion counters, advancing on the edge that raises each pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_fire && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (mem_we && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed self-checking bench for mem_block_ctrl: LATENCY=3 instance plus a
// LATENCY=1 instance; counter checks apply when MEM_CTRL_STATS_EN is defined.
module tb_mem_block_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BS = 4;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          rd_en0, wr_en0, rv0, wd0, busy0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [DW-1:0] wr_data0 [BS];
  logic [DW-1:0] rdata0   [BS];

  logic          rd_en1, wr_en1, rv1, wd1, busy1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] wr_data1 [BS];
  logic [DW-1:0] rdata1   [BS];

`ifdef MEM_CTRL_STATS_EN
  logic [15:0]   rdc0, wrc0, rdc1, wrc1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_block_ctrl #(.LATENCY(3)) u0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en0),
    .rd_address (rd_addr0),
    .wr_en      (wr_en0),
    .wr_address (wr_addr0),
    .wr_data    (wr_data0),
    .ram_valid  (rv0),
    .ram_data   (rdata0),
    .wr_done    (wd0),
`ifdef MEM_CTRL_STATS_EN
    .rd_count   (rdc0),
    .wr_count   (wrc0),
`endif
    .busy       (busy0)
  );

  mem_block_ctrl #(.LATENCY(1)) u1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en1),
    .rd_address (rd_addr1),
    .wr_en      (wr_en1),
    .wr_address (wr_addr1),
    .wr_data    (wr_data1),
    .ram_valid  (rv1),
    .ram_data   (rdata1),
    .wr_done    (wd1),
`ifdef MEM_CTRL_STATS_EN
    .rd_count   (rdc1),
    .wr_count   (wrc1),
`endif
    .busy       (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [DW-1:0] got [BS],
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [BS];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < BS; k++) check_eq($sformatf("%s[%0d]", tag, k), got[k], e[k]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the capture edge until ram_valid on u0 (bounded).
  task automatic wait_rv0(output int n);
    n = 0;
    while (!rv0 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic wait_wd0(output int n);
    n = 0;
    while (!wd0 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic read0(input logic [AW-1:0] a);
    rd_addr0 = a;
    rd_en0   = 1'b1;
    step();
    rd_en0   = 1'b0;
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    wr_addr0 = a;
    wr_data0 = '{d0, d1, d2, d3};
    wr_en0   = 1'b1;
    step();
    wr_en0   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    reset_n  = 1'b0;
    rd_en0   = 1'b0; wr_en0 = 1'b0; rd_addr0 = '0; wr_addr0 = '0;
    rd_en1   = 1'b0; wr_en1 = 1'b0; rd_addr1 = '0; wr_addr1 = '0;
    wr_data0 = '{default: '0};
    wr_data1 = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_valid", 32'(rv0), 32'd0);
    check_eq("rst_wr_done", 32'(wd0), 32'd0);
    check_blk("rst_data", rdata0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset_n = 1'b1;
    step();

    // Plain fill of 0x015: three busy cycles, pulse after E0+3.
    read0(10'h015);
    check_eq("rd_e0_busy", 32'(busy0), 32'd1);
    check_eq("rd_e0_valid", 32'(rv0), 32'd0);
    step();
    check_eq("rd_e1_busy", 32'(busy0), 32'd1);
    step();
    check_eq("rd_e2_busy", 32'(busy0), 32'd1);
    check_eq("rd_e2_valid", 32'(rv0), 32'd0);
    step();
    check_eq("rd_e3_valid", 32'(rv0), 32'd1);
    check_eq("rd_e3_busy", 32'(busy0), 32'd0);
    check_blk("rd015", rdata0, 32'h014, 32'h015, 32'h016, 32'h017);
    step();
    check_eq("rd_e4_valid", 32'(rv0), 32'd0);

    // Writeback only, offset bits of the address ignored.
    write0(10'h082, 32'h11, 32'h22, 32'h33, 32'h44);
    wait_wd0(n);
    check_eq("wb_lat", 32'(n), 32'd3);
    check_eq("wb_no_valid", 32'(rv0), 32'd0);
    check_eq("wb_busy_after", 32'(busy0), 32'd0);
    step();
    check_eq("wb_done_pulse", 32'(wd0), 32'd0);
    read0(10'h080);
    wait_rv0(n);
    check_eq("wb_rd_lat", 32'(n), 32'd3);
    check_blk("wb_rd", rdata0, 32'h11, 32'h22, 32'h33, 32'h44);

    // Combined writeback 0x020 + fill 0x022 in the same cycle.
    wr_addr0 = 10'h020;
    wr_data0 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rd_addr0 = 10'h022;
    wr_en0 = 1'b1; rd_en0 = 1'b1;
    step();
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    wait_wd0(n);
    check_eq("cmb_wd_lat", 32'(n), 32'd3);
    check_eq("cmb_busy_mid", 32'(busy0), 32'd1);
    check_eq("cmb_rv_mid", 32'(rv0), 32'd0);
    wait_rv0(n);
    check_eq("cmb_rv_lat", 32'(n), 32'd3);
    check_eq("cmb_wd_low", 32'(wd0), 32'd0);
    check_blk("cmb_data", rdata0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Request while busy is dropped, not queued.
    read0(10'h100);
    rd_addr0 = 10'h200;
    rd_en0   = 1'b1;
    wait_rv0(n);
    rd_en0   = 1'b0;
    check_eq("ign_lat", 32'(n), 32'd3);
    check_blk("ign_data", rdata0, 32'h100, 32'h101, 32'h102, 32'h103);
    p = 0;
    repeat (8) begin
      step();
      if (rv0) p++;
    end
    check_eq("ign_extra_pulses", 32'(p), 32'd0);
    check_eq("ign_idle", 32'(busy0), 32'd0);
    check_blk("ign_hold", rdata0, 32'h100, 32'h101, 32'h102, 32'h103);
    read0(10'h200);
    wait_rv0(n);
    check_blk("rd200", rdata0, 32'h200, 32'h201, 32'h202, 32'h203);

    // Async reset mid-fill.
    read0(10'h040);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy0), 32'd0);
    check_eq("arst_valid", 32'(rv0), 32'd0);
    check_blk("arst_data", rdata0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    reset_n = 1'b1;
    p = 0;
    repeat (6) begin
      step();
      if (rv0) p++;
    end
    check_eq("arst_no_pulse", 32'(p), 32'd0);
    read0(10'h3FF);
    wait_rv0(n);
    check_eq("rd3ff_lat", 32'(n), 32'd3);
    check_blk("rd3ff", rdata0, 32'h3FC, 32'h3FD, 32'h3FE, 32'h3FF);

    // Writeback killed by reset before commit leaves the array untouched.
    write0(10'h050, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    step();
    #2 reset_n = 1'b0;
    #1;
    check_eq("wrst_busy", 32'(busy0), 32'd0);
    step();
    reset_n = 1'b1;
    p = 0;
    repeat (6) begin
      step();
      if (wd0) p++;
    end
    check_eq("wrst_no_done", 32'(p), 32'd0);
    read0(10'h050);
    wait_rv0(n);
    check_blk("wrst_rd050", rdata0, 32'h050, 32'h051, 32'h052, 32'h053);

    // LATENCY=1: back-to-back fills, second captured in the ram_valid cycle.
    rd_addr1 = 10'h000;
    rd_en1   = 1'b1;
    step();
    check_eq("l1_e0_busy", 32'(busy1), 32'd1);
    check_eq("l1_e0_valid", 32'(rv1), 32'd0);
    rd_addr1 = 10'h004;
    step();
    check_eq("l1_e1_valid", 32'(rv1), 32'd1);
    check_eq("l1_e1_busy", 32'(busy1), 32'd0);
    check_blk("l1_rd000", rdata1, 32'h0, 32'h1, 32'h2, 32'h3);
    step();
    rd_en1 = 1'b0;
    check_eq("l1_e2_valid", 32'(rv1), 32'd0);
    check_eq("l1_e2_busy", 32'(busy1), 32'd1);
    step();
    check_eq("l1_e3_valid", 32'(rv1), 32'd1);
    check_blk("l1_rd004", rdata1, 32'h4, 32'h5, 32'h6, 32'h7);
`ifdef MEM_CTRL_STATS_EN
    check_eq("l1_rd_count", 32'(rdc1), 32'd2);
    check_eq("l1_wr_count", 32'(wrc1), 32'd0);
`endif
    step();
    check_eq("l1_e4_valid", 32'(rv1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
